// File: rtl/foxtrot_pkg.sv
// foxtrot_pkg: LRN constants, FU encoding and PRN typedef shared by the rename slice.
package foxtrot_pkg;
  localparam int LRN_W         = 6;
  localparam int LRN_FLAGS     = 32;
  localparam int LRN_ZERO      = 63;
  localparam int NUM_ARCH_REGS = 33;
  localparam int NUM_PRN_DFLT  = 96;
  localparam int PRN_W_DFLT    = $clog2(NUM_PRN_DFLT);

  typedef logic [LRN_W-1:0]      lrn_t;
  typedef logic [PRN_W_DFLT-1:0] prn_t;

  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_MUL = 3'd1,
    FU_DIV = 3'd2,
    FU_LSU = 3'd3,
    FU_BRU = 3'd4,
    FU_FPU = 3'd5
  } fu_e;

  function automatic logic lrn_is_zero(input lrn_t lrn);
    return lrn == LRN_W'(LRN_ZERO);
  endfunction
endpackage

// File: rtl/prn_free_list.sv
// prn_free_list: bitmap of free PRNs with a lowest-first multi-grant allocator and popcount.
// RENAME_FLUSH_EN adds the committed_used bitmap that flush reloads the free list from.
module prn_free_list
  import foxtrot_pkg::*;
#(
  parameter int NUM_PRN  = 96,
  parameter int PRN_W    = $clog2(NUM_PRN),
  parameter int NUM_SLOT = 3,
  parameter int CNT_W    = $clog2(NUM_PRN + 1),
  parameter int ALLOC_W  = $clog2(NUM_SLOT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_en,
  input  logic [ALLOC_W-1:0]  alloc_cnt,
  output logic [PRN_W-1:0]    grant [NUM_SLOT],
  output logic [CNT_W-1:0]    free_cnt,
  input  logic [NUM_SLOT-1:0] commit_valid,
  input  logic [PRN_W-1:0]    commit_prn [NUM_SLOT],
  input  logic [PRN_W-1:0]    commit_old_prn [NUM_SLOT],
  input  logic                flush
);
  localparam logic [NUM_PRN-1:0] FREE_RST = {NUM_PRN{1'b1}} << (NUM_ARCH_REGS + 1);
  localparam logic [NUM_PRN-1:0] BIT0     = {{(NUM_PRN-1){1'b0}}, 1'b1};

  logic [NUM_PRN-1:0] free_q, free_nxt, avail;

  // A slot that finds nothing returns 0; the caller never consumes it.
  always_comb begin
    avail = free_q;
    for (int k = 0; k < NUM_SLOT; k++) begin
      grant[k] = '0;
      for (int i = NUM_PRN - 1; i >= 1; i--)
        if (avail[i]) grant[k] = PRN_W'(i);
      avail[grant[k]] = 1'b0;
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < NUM_PRN; i++) free_cnt = free_cnt + CNT_W'(free_q[i]);
  end

  always_comb begin
    free_nxt = free_q;
    for (int k = 0; k < NUM_SLOT; k++)
      if (alloc_en && (ALLOC_W'(k) < alloc_cnt)) free_nxt[grant[k]] = 1'b0;
    for (int k = 0; k < NUM_SLOT; k++)
      if (commit_valid[k] && (commit_old_prn[k] != '0)) free_nxt[commit_old_prn[k]] = 1'b1;
  end

`ifdef RENAME_FLUSH_EN
  logic [NUM_PRN-1:0] used_q, used_nxt;

  always_comb begin
    used_nxt = used_q;
    for (int k = 0; k < NUM_SLOT; k++)
      if (commit_valid[k]) begin
        used_nxt[commit_old_prn[k]] = 1'b0;
        used_nxt[commit_prn[k]]     = 1'b1;
      end
  end

  always_ff @(posedge clk) begin
    if (rst) used_q <= ~FREE_RST & ~BIT0;
    else     used_q <= used_nxt;
  end
`else
  logic unused_cfg;
  always_comb begin
    unused_cfg = flush;
    for (int k = 0; k < NUM_SLOT; k++) unused_cfg = unused_cfg ^ (^commit_prn[k]);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) free_q <= FREE_RST;
`ifdef RENAME_FLUSH_EN
    else if (flush) free_q <= ~used_nxt & ~BIT0;
`endif
    else free_q <= free_nxt;
  end
endmodule

// File: rtl/rename_stage.sv
// rename_stage: maps decoded LRNs to PRNs through a speculative RAT and registers the result for dispatch.
// Optional RENAME_FLUSH_EN adds a committed RAT so flush can roll speculative state back.
module rename_stage
  import foxtrot_pkg::*;
#(
  parameter int NUM_PRN      = 96,
  parameter int PRN_W        = $clog2(NUM_PRN),
  parameter int MAX_OPERANDS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [2:0]              in_fu,
  input  logic [5:0]              in_lrn_src [MAX_OPERANDS],
  input  logic [5:0]              in_lrn_dst [MAX_OPERANDS],
  input  logic [MAX_OPERANDS-1:0] in_src_mask,
  input  logic [MAX_OPERANDS-1:0] in_dst_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  output logic [2:0]              out_fu,
  output logic [PRN_W-1:0]        out_prn_src [MAX_OPERANDS],
  output logic [PRN_W-1:0]        out_prn_dst [MAX_OPERANDS],
  output logic [PRN_W-1:0]        out_prn_old [MAX_OPERANDS],
  output logic [MAX_OPERANDS-1:0] out_dst_mask,
  input  logic [MAX_OPERANDS-1:0] commit_valid,
  input  logic [5:0]              commit_lrn [MAX_OPERANDS],
  input  logic [PRN_W-1:0]        commit_prn [MAX_OPERANDS],
  input  logic [PRN_W-1:0]        commit_old_prn [MAX_OPERANDS],
  input  logic                    flush
);
  localparam int NUM_LRN = 1 << LRN_W;
  localparam int CNT_W   = $clog2(MAX_OPERANDS + 1);
  localparam int FREE_W  = $clog2(NUM_PRN + 1);

  logic [PRN_W-1:0]        rat_q   [NUM_LRN];
  logic [PRN_W-1:0]        src_prn [MAX_OPERANDS];
  logic [PRN_W-1:0]        dst_prn [MAX_OPERANDS];
  logic [PRN_W-1:0]        old_prn [MAX_OPERANDS];
  logic [PRN_W-1:0]        grant   [MAX_OPERANDS];
  logic [MAX_OPERANDS-1:0] dst_live;
  logic [CNT_W-1:0]        need_cnt;
  logic [FREE_W-1:0]       free_cnt;
  logic                    flush_eff, accept;

  function automatic logic [PRN_W-1:0] rat_rst(input int i);
    return (i < NUM_ARCH_REGS) ? PRN_W'(i + 1) : '0;
  endfunction

`ifdef RENAME_FLUSH_EN
  logic [PRN_W-1:0] crat_q   [NUM_LRN];
  logic [PRN_W-1:0] crat_nxt [NUM_LRN];

  assign flush_eff = flush;

  // Flush restores from crat_nxt so commits landing in the flush cycle are kept.
  always_comb begin
    crat_nxt = crat_q;
    for (int k = 0; k < MAX_OPERANDS; k++)
      if (commit_valid[k] && !lrn_is_zero(commit_lrn[k])) crat_nxt[commit_lrn[k]] = commit_prn[k];
  end

  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NUM_LRN; i++) crat_q[i] <= rat_rst(i);
    else     crat_q <= crat_nxt;
  end
`else
  logic unused_commit;
  assign flush_eff = 1'b0;
  always_comb begin
    unused_commit = flush;
    for (int k = 0; k < MAX_OPERANDS; k++) unused_commit = unused_commit ^ (^commit_lrn[k]);
  end
`endif

  // Sources see the RAT before this instruction; a repeated destination chains its old PRN.
  always_comb begin
    need_cnt = '0;
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      src_prn[k] = '0;
      if (in_src_mask[k] && !lrn_is_zero(in_lrn_src[k])) src_prn[k] = rat_q[in_lrn_src[k]];
      dst_live[k] = in_dst_mask[k] && !lrn_is_zero(in_lrn_dst[k]);
      dst_prn[k]  = '0;
      old_prn[k]  = '0;
      if (dst_live[k]) begin
        dst_prn[k] = grant[need_cnt];
        old_prn[k] = rat_q[in_lrn_dst[k]];
        for (int j = 0; j < k; j++)
          if (dst_live[j] && (in_lrn_dst[j] == in_lrn_dst[k])) old_prn[k] = dst_prn[j];
        need_cnt = need_cnt + 1'b1;
      end
    end
  end

  assign in_ready = (!out_valid || out_ready) && (free_cnt >= FREE_W'(need_cnt)) && !flush_eff;
  assign accept   = in_valid && in_ready;

  prn_free_list #(
    .NUM_PRN (NUM_PRN),
    .PRN_W   (PRN_W),
    .NUM_SLOT(MAX_OPERANDS)
  ) u_free_list (
    .clk           (clk),
    .rst           (rst),
    .alloc_en      (accept),
    .alloc_cnt     (need_cnt),
    .grant         (grant),
    .free_cnt      (free_cnt),
    .commit_valid  (commit_valid),
    .commit_prn    (commit_prn),
    .commit_old_prn(commit_old_prn),
    .flush         (flush_eff)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LRN; i++) rat_q[i] <= rat_rst(i);
    end
`ifdef RENAME_FLUSH_EN
    else if (flush_eff) begin
      rat_q <= crat_nxt;
    end
`endif
    else if (accept) begin
      for (int k = 0; k < MAX_OPERANDS; k++)
        if (dst_live[k]) rat_q[in_lrn_dst[k]] <= dst_prn[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_instr    <= '0;
      out_fu       <= '0;
      out_dst_mask <= '0;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        out_prn_src[k] <= '0;
        out_prn_dst[k] <= '0;
        out_prn_old[k] <= '0;
      end
    end else if (flush_eff) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_instr    <= in_instr;
      out_fu       <= in_fu;
      out_dst_mask <= dst_live;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        out_prn_src[k] <= src_prn[k];
        out_prn_dst[k] <= dst_prn[k];
        out_prn_old[k] <= old_prn[k];
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: scoreboard bench for rename_stage; expected renames come from a behavioural RAT/free-list model.
module tb_rename_stage;
  localparam int NUM_PRN = 96;
  localparam int PRN_W   = 7;
`ifdef RENAME_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0]      in_instr, out_instr;
  logic [2:0]       in_fu, out_fu, in_src_mask, in_dst_mask, out_dst_mask, commit_valid;
  logic [5:0]       in_lrn_src [3];
  logic [5:0]       in_lrn_dst [3];
  logic [5:0]       commit_lrn [3];
  logic [PRN_W-1:0] out_prn_src [3];
  logic [PRN_W-1:0] out_prn_dst [3];
  logic [PRN_W-1:0] out_prn_old [3];
  logic [PRN_W-1:0] commit_prn [3];
  logic [PRN_W-1:0] commit_old_prn [3];

  rename_stage #(.NUM_PRN(NUM_PRN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_fu(in_fu), .in_lrn_src(in_lrn_src), .in_lrn_dst(in_lrn_dst),
    .in_src_mask(in_src_mask), .in_dst_mask(in_dst_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_fu(out_fu),
    .out_prn_src(out_prn_src), .out_prn_dst(out_prn_dst), .out_prn_old(out_prn_old),
    .out_dst_mask(out_dst_mask), .commit_valid(commit_valid), .commit_lrn(commit_lrn),
    .commit_prn(commit_prn), .commit_old_prn(commit_old_prn), .flush(flush)
  );

  typedef struct packed {
    logic [31:0]        instr;
    logic [2:0]         fu;
    logic [3*PRN_W-1:0] src;
    logic [3*PRN_W-1:0] dst;
    logic [3*PRN_W-1:0] old;
    logic [2:0]         mask;
  } exp_t;

  exp_t             exp_q [$];
  int               n_checks = 0;
  int               n_errors = 0;
  logic [PRN_W-1:0] m_rat [64];
  logic [PRN_W-1:0] m_crat [64];
  logic [NUM_PRN-1:0] m_free, m_used;
  logic             m_ovalid;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_rat[i]  = (i < 33) ? PRN_W'(i + 1) : '0;
      m_crat[i] = m_rat[i];
    end
    m_free = '0;
    m_used = '0;
    for (int i = 1; i < NUM_PRN; i++)
      if (i >= 34) m_free[i] = 1'b1;
      else         m_used[i] = 1'b1;
    m_ovalid = 1'b0;
    exp_q.delete();
  endtask

  function automatic int popcnt();
    int c = 0;
    for (int i = 0; i < NUM_PRN; i++) c += int'(m_free[i]);
    return c;
  endfunction

  function automatic int need();
    int c = 0;
    for (int k = 0; k < 3; k++) if (in_dst_mask[k] && in_lrn_dst[k] != 6'd63) c++;
    return c;
  endfunction

  task automatic model_rename();
    exp_t e;
    logic [PRN_W-1:0] tmp [64];
    logic [PRN_W-1:0] p;
    tmp = m_rat;
    e = '0;
    e.instr = in_instr;
    e.fu    = in_fu;
    for (int k = 0; k < 3; k++)
      if (in_src_mask[k] && in_lrn_src[k] != 6'd63) e.src[k*PRN_W +: PRN_W] = m_rat[in_lrn_src[k]];
    for (int k = 0; k < 3; k++)
      if (in_dst_mask[k] && in_lrn_dst[k] != 6'd63) begin
        p = '0;
        for (int i = 1; i < NUM_PRN; i++) if (m_free[i]) begin p = PRN_W'(i); break; end
        m_free[p] = 1'b0;
        e.dst[k*PRN_W +: PRN_W] = p;
        e.old[k*PRN_W +: PRN_W] = tmp[in_lrn_dst[k]];
        tmp[in_lrn_dst[k]] = p;
        e.mask[k] = 1'b1;
      end
    m_rat = tmp;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    logic rdy, fl;
    exp_t e;
    #1;
    fl  = FLUSH_EN && flush;
    rdy = (!m_ovalid || out_ready) && (popcnt() >= need()) && !fl;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, m_ovalid);
    if (m_ovalid) begin
      if (exp_q.size() == 0) chk("sb_underflow", out_valid, 1'b0);
      else begin
        e = exp_q[0];
        chk("out_instr", out_instr, e.instr);
        chk("out_fu", out_fu, e.fu);
        chk("out_src", {out_prn_src[2], out_prn_src[1], out_prn_src[0]}, e.src);
        chk("out_dst", {out_prn_dst[2], out_prn_dst[1], out_prn_dst[0]}, e.dst);
        chk("out_old", {out_prn_old[2], out_prn_old[1], out_prn_old[0]}, e.old);
        chk("out_mask", out_dst_mask, e.mask);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (rst) model_reset();
    else begin
      if (in_valid && rdy) model_rename();
      m_ovalid = (in_valid && rdy) ? 1'b1 : (out_ready ? 1'b0 : m_ovalid);
      for (int k = 0; k < 3; k++)
        if (commit_valid[k]) begin
          if (commit_old_prn[k] != '0) m_free[commit_old_prn[k]] = 1'b1;
          m_used[commit_old_prn[k]] = 1'b0;
          m_used[commit_prn[k]]     = 1'b1;
          if (commit_lrn[k] != 6'd63) m_crat[commit_lrn[k]] = commit_prn[k];
        end
      if (fl) begin
        m_rat     = m_crat;
        m_free    = ~m_used;
        m_free[0] = 1'b0;
        m_ovalid  = 1'b0;
        exp_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] instr, input logic [17:0] src, input logic [2:0] smask,
                           input logic [17:0] dst, input logic [2:0] dmask);
    in_valid    = 1'b1;
    in_instr    = instr;
    in_fu       = instr[2:0];
    in_src_mask = smask;
    in_dst_mask = dmask;
    for (int k = 0; k < 3; k++) begin
      in_lrn_src[k] = src[k*6 +: 6];
      in_lrn_dst[k] = dst[k*6 +: 6];
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_fu = '0; in_src_mask = '0; in_dst_mask = '0;
    out_ready = 1'b1; commit_valid = '0; flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_lrn_src[k] = '0; in_lrn_dst[k] = '0; commit_lrn[k] = '0;
      commit_prn[k] = '0; commit_old_prn[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_dst", {out_prn_dst[2], out_prn_dst[1], out_prn_dst[0], out_prn_old[0]}, 28'd0);
    chk("rst_in_ready", in_ready, 1'b1);

    // ADDS x3,x1,x2 also writes flags
    set_instr(32'h0b02_0020, {6'd0, 6'd2, 6'd1}, 3'b011, {6'd0, 6'd32, 6'd3}, 3'b011);
    tick();
    chk("adds_valid", out_valid, 1'b1);
    chk("adds_src", {out_prn_src[1], out_prn_src[0]}, {7'd3, 7'd2});
    chk("adds_dst", {out_prn_dst[1], out_prn_dst[0]}, {7'd35, 7'd34});
    chk("adds_old", {out_prn_old[1], out_prn_old[0]}, {7'd33, 7'd4});
    set_instr(32'h0b03_0051, {6'd0, 6'd0, 6'd3}, 3'b001, {6'd0, 6'd0, 6'd5}, 3'b001);
    tick();
    chk("add_dst", out_prn_dst[0], 7'd36);
    set_instr(32'h4b05_0062, {6'd0, 6'd0, 6'd5}, 3'b001, {6'd0, 6'd0, 6'd6}, 3'b001);
    tick();
    chk("sub_src", out_prn_src[0], 7'd36);
    chk("sub_dst", out_prn_dst[0], 7'd37);
    in_valid = 1'b0;
    tick();

    // LDP x1,x1,[x2]
    do_reset();
    set_instr(32'ha940_0443, {6'd0, 6'd0, 6'd2}, 3'b001, {6'd0, 6'd1, 6'd1}, 3'b011);
    tick();
    chk("ldp_dst", {out_prn_dst[1], out_prn_dst[0]}, {7'd35, 7'd34});
    chk("ldp_old", {out_prn_old[1], out_prn_old[0]}, {7'd34, 7'd2});
    set_instr(32'h0b01_0084, {6'd63, 6'd0, 6'd1}, 3'b101, {6'd0, 6'd63, 6'd4}, 3'b011);
    tick();
    chk("ldp_rat", out_prn_src[0], 7'd35);
    chk("zero_src", out_prn_src[2], 7'd0);
    chk("zero_dst_mask", out_dst_mask, 3'b001);

    // Dispatch backpressure
    out_ready = 1'b0;
    set_instr(32'h0000_0105, {6'd0, 6'd0, 6'd7}, 3'b001, {6'd0, 6'd0, 6'd8}, 3'b001);
    tick();
    set_instr(32'h0000_0106, {6'd0, 6'd0, 6'd8}, 3'b001, {6'd0, 6'd0, 6'd9}, 3'b001);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();

    // Random traffic with random dispatch stalls
    for (int i = 0; i < 30; i++) begin
      set_instr($urandom, {6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))},
                3'($urandom), {6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))},
                3'($urandom));
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();

    // Free-list exhaustion and commit refill
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_instr(32'h0000_0200 + i, {6'd0, 6'd0, 6'd0}, 3'b000, {6'd2, 6'd1, 6'd0}, 3'b111);
      tick();
    end
    set_instr(32'h0000_0300, {6'd0, 6'd0, 6'd0}, 3'b000, {6'd0, 6'd11, 6'd10}, 3'b011);
    tick();
    set_instr(32'h0000_0301, {6'd0, 6'd0, 6'd0}, 3'b000, {6'd0, 6'd0, 6'd7}, 3'b001);
    #1 chk("exh_ready", in_ready, 1'b0);
    tick();
    commit_valid = 3'b001; commit_lrn[0] = 6'd1; commit_prn[0] = 7'd35; commit_old_prn[0] = 7'd2;
    #1 chk("exh_no_bypass", in_ready, 1'b0);
    tick();
    commit_valid = 3'b000;
    #1 chk("exh_reraise", in_ready, 1'b1);
    tick();
    chk("exh_alloc", out_prn_dst[0], 7'd2);
    in_valid = 1'b0;
    tick();

`ifdef RENAME_FLUSH_EN
    do_reset();
    set_instr(32'h0000_0400, {6'd0, 6'd0, 6'd0}, 3'b000, {6'd0, 6'd0, 6'd1}, 3'b001);
    tick();
    chk("fl_first", out_prn_dst[0], 7'd34);
    commit_valid = 3'b001; commit_lrn[0] = 6'd1; commit_prn[0] = 7'd34; commit_old_prn[0] = 7'd2;
    tick();
    chk("fl_second", out_prn_dst[0], 7'd35);
    commit_valid = 3'b000;
    in_valid = 1'b0;
    flush = 1'b1;
    #1 chk("fl_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0;
    chk("fl_out_valid", out_valid, 1'b0);
    set_instr(32'h0000_0401, {6'd0, 6'd0, 6'd1}, 3'b001, {6'd0, 6'd0, 6'd1}, 3'b001);
    tick();
    chk("fl_rat", out_prn_src[0], 7'd34);
    chk("fl_free2", out_prn_dst[0], 7'd2);
    set_instr(32'h0000_0402, {6'd0, 6'd0, 6'd0}, 3'b000, {6'd0, 6'd0, 6'd3}, 3'b001);
    tick();
    chk("fl_free35", out_prn_dst[0], 7'd35);
    in_valid = 1'b0;
    tick();
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
